// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Bundle of hazard-detection inputs and stage-control outputs
//                exchanged between the pipeline datapath and the hazard
//                controller.
//                slave  modport: used by the hazard controller
//                master modport: used by the datapath (or a testbench)
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID stage operand usage
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs1_i;
    logic             id_uses_rs2_i;
    // EX stage
    logic [4:0]       ex_rs1_i;
    logic [4:0]       ex_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             ex_busy_i;
    // MEM / WB write-back targets
    logic [4:0]       mem_rd_i;
    logic             mem_regwrite_i;
    logic [4:0]       wb_rd_i;
    logic             wb_regwrite_i;
    // redirect and counter clear
    logic             pc_select_i;
    logic             cnt_clr_i;
    // stage controls
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             ex_hold_o;
    logic             mem_bubble_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  ex_rs1_i, ex_rs2_i, ex_rd_i, ex_memread_i, ex_busy_i,
        input  mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i,
        input  pc_select_i, cnt_clr_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
        output ex_hold_o, mem_bubble_o, fwd_a_o, fwd_b_o, state_o,
        output stall_cnt_o, flush_cnt_o
    );

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output ex_rs1_i, ex_rs2_i, ex_rd_i, ex_memread_i, ex_busy_i,
        output mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i,
        output pc_select_i, cnt_clr_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
        input  ex_hold_o, mem_bubble_o, fwd_a_o, fwd_b_o, state_o,
        input  stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Execute-stage hazard controller for a 5-stage pipeline.
//                Detects load-use hazards, holds the pipe while a multi-cycle
//                EX op is busy, flushes IF/ID and ID/EX after an EX redirect,
//                selects ALU operand forwarding and keeps saturating
//                stall / flush performance counters.
//  Ports       : clk_i    - clock, rising edge
//                reset_i  - asynchronous active-high reset
//                hz       - hazard bundle (slave modport): ID/EX/MEM/WB
//                           register info in; stage controls, forwarding
//                           selects, FSM state and counters out
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // legal range 1..7
    parameter int CNT_W        = 16
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Cycles left in FLUSH after the redirect cycle itself (which is spent in RUN).
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       fcnt;
    logic [2:0]       fcnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic             load_use;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic             mem_bubble;
    logic             redirect_taken;

    assign load_use = hz.ex_memread_i && (hz.ex_rd_i != 5'd0) &&
                      ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                       (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stage controls (priority: redirect > busy > load-use)
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        fcnt_nxt       = fcnt;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        mem_bubble     = 1'b0;
        redirect_taken = 1'b0;

        case (state)
            ST_RUN: begin
                if (hz.pc_select_i) begin
                    if_id_flush    = 1'b1;
                    id_ex_bubble   = 1'b1;
                    redirect_taken = 1'b1;
                    // A single-cycle flush completes in this cycle.
                    if (FLUSH_INIT != 3'd0) begin
                        state_nxt = ST_FLUSH;
                        fcnt_nxt  = FLUSH_INIT;
                    end
                end else if (hz.ex_busy_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    ex_hold     = 1'b1;
                    mem_bubble  = 1'b1;
                    state_nxt   = ST_HOLD;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end

            // EX is frozen, so a redirect request cannot originate from it.
            ST_HOLD: begin
                if (hz.ex_busy_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    ex_hold     = 1'b1;
                    mem_bubble  = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end

            // Everything younger than the redirecting instruction is being
            // squashed, so its hazards are irrelevant.
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                fcnt_nxt     = (fcnt == 3'd0) ? 3'd0 : fcnt - 3'd1;
                if (fcnt <= 3'd1) begin
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_RUN;
                fcnt_nxt  = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating performance counters; clear beats increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.cnt_clr_i) begin
                stall_cnt <= '0;
            end else if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (hz.cnt_clr_i) begin
                flush_cnt <= '0;
            end else if (redirect_taken && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding: MEM is younger than WB so it wins; x0 never forwards
    // ------------------------------------------------------------------
    always_comb begin
        hz.fwd_a_o = 2'b00;
        if (hz.mem_regwrite_i && (hz.mem_rd_i != 5'd0) && (hz.mem_rd_i == hz.ex_rs1_i)) begin
            hz.fwd_a_o = 2'b10;
        end else if (hz.wb_regwrite_i && (hz.wb_rd_i != 5'd0) && (hz.wb_rd_i == hz.ex_rs1_i)) begin
            hz.fwd_a_o = 2'b01;
        end
    end

    always_comb begin
        hz.fwd_b_o = 2'b00;
        if (hz.mem_regwrite_i && (hz.mem_rd_i != 5'd0) && (hz.mem_rd_i == hz.ex_rs2_i)) begin
            hz.fwd_b_o = 2'b10;
        end else if (hz.wb_regwrite_i && (hz.wb_rd_i != 5'd0) && (hz.wb_rd_i == hz.ex_rs2_i)) begin
            hz.fwd_b_o = 2'b01;
        end
    end

    assign hz.pc_stall_o     = pc_stall;
    assign hz.if_id_stall_o  = if_id_stall;
    assign hz.if_id_flush_o  = if_id_flush;
    assign hz.id_ex_bubble_o = id_ex_bubble;
    assign hz.ex_hold_o      = ex_hold;
    assign hz.mem_bubble_o   = mem_bubble;
    assign hz.state_o        = state;
    assign hz.stall_cnt_o    = stall_cnt;
    assign hz.flush_cnt_o    = flush_cnt;

endmodule
`default_nettype wire
